// File: rtl/router_input_unit.sv
// Router input unit: circular flit buffer with an XY route-computation FSM.
// Each packet is routed once, from its head flit; later flits follow that route.
module router_input_unit #(
    parameter int          LINK_WIDTH = 35,
    parameter int          ARITY      = 5,
    parameter int          DEPTH      = 4,
    parameter logic [3:0]  CUR_X      = 4'd1,
    parameter logic [3:0]  CUR_Y      = 4'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_req,
    input  logic [LINK_WIDTH-1:0] in_data,
    output logic                  in_ack,
    output logic                  out_req,
    output logic [LINK_WIDTH-1:0] out_data,
    input  logic                  out_ack,
    output logic [ARITY-1:0]      out_route,
    output logic                  protocol_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, ROUTED} state_t;

    logic [LINK_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    state_t                state, state_nxt;
    logic                  pkt_open;
    logic                  wr_en, rd_en, route_ld, err_set, req_c;
    logic                  nonempty;
    logic [1:0]            head_type;
    logic [3:0]            dx, dy;

    // Type bit 0 marks a packet start (head/single), bit 1 a packet end (tail/single).
    function automatic logic [ARITY-1:0] xy_route(input logic [3:0] x, input logic [3:0] y);
        logic [ARITY-1:0] r;
        r = '0;
        if (x > CUR_X)      r[2] = 1'b1;
        else if (x < CUR_X) r[4] = 1'b1;
        else if (y > CUR_Y) r[1] = 1'b1;
        else if (y < CUR_Y) r[3] = 1'b1;
        else                r[0] = 1'b1;
        return r;
    endfunction

    assign out_data  = mem[rd_ptr];
    assign head_type = out_data[LINK_WIDTH-1 -: 2];
    assign dx        = out_data[7:4];
    assign dy        = out_data[3:0];
    assign nonempty  = (count != '0);
    assign in_ack    = (count < FULL);
    assign wr_en     = in_req && in_ack;
    assign out_req   = req_c && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        rd_en     = 1'b0;
        route_ld  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (nonempty) begin
                    if (head_type[0]) begin
                        route_ld  = 1'b1;
                        state_nxt = ROUTED;
                    end else begin
                        // Orphan body/tail with no routed packet: discard it.
                        rd_en   = 1'b1;
                        err_set = 1'b1;
                    end
                end
            end
            ROUTED: begin
                req_c = nonempty;
                if (nonempty && out_ack) begin
                    rd_en = 1'b1;
                    // A start flit other than the one that was routed means a missing tail.
                    if (head_type[0] && !pkt_open) err_set = 1'b1;
                    if (head_type[1]) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_route    <= '0;
            protocol_err <= 1'b0;
            pkt_open     <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (route_ld) out_route <= xy_route(dx, dy);
            if (err_set)  protocol_err <= 1'b1;
            if (route_ld)                       pkt_open <= 1'b1;
            else if (rd_en && state == ROUTED)  pkt_open <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit: per-cycle vector table plus a
// hand-written sequence for the missing-tail protocol error.
module tb_router_input_unit;

    logic        clk = 1'b0;
    logic        rst, in_req, in_ack, out_req, out_ack, protocol_err;
    logic [34:0] in_data, out_data;
    logic [4:0]  out_route;

    int checks = 0;
    int errors = 0;

    router_input_unit dut (
        .clk(clk), .rst(rst), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
        .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .out_route(out_route), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, req, oack;
        logic [34:0] din;
        logic        e_iack, e_req;
        logic [4:0]  e_route;
        logic        e_err;
        logic [34:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [34:0] mk(input logic [1:0] t, input logic [24:0] p,
                                       input logic [3:0] x, input logic [3:0] y);
        return {t, p, x, y};
    endfunction

    function automatic vec_t v(input logic r, input logic q, input logic [34:0] d, input logic a,
                               input logic ei, input logic eq, input logic [4:0] er,
                               input logic ee, input logic [34:0] ed);
        vec_t x;
        x.rst = r; x.req = q; x.din = d; x.oack = a;
        x.e_iack = ei; x.e_req = eq; x.e_route = er; x.e_err = ee; x.e_data = ed;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge, check on the falling edge.
    task automatic cyc(input string tag, input vec_t x);
        rst = x.rst; in_req = x.req; in_data = x.din; out_ack = x.oack;
        @(negedge clk);
        chk({tag, " in_ack"}, 64'(in_ack), 64'(x.e_iack));
        chk({tag, " out_req"}, 64'(out_req), 64'(x.e_req));
        chk({tag, " out_route"}, 64'(out_route), 64'(x.e_route));
        chk({tag, " protocol_err"}, 64'(protocol_err), 64'(x.e_err));
        if (x.e_req) chk({tag, " out_data"}, 64'(out_data), 64'(x.e_data));
        @(posedge clk);
        #1;
    endtask

    logic [34:0] S, H, B1, B2, T, W, WT, P0, P1, P2, P3, P4, BD, Q0, Q1, L, A, B, A2, TT;

    initial begin
        S  = mk(2'b11, 25'h0, 4'd2, 4'd3);
        H  = mk(2'b01, 25'h11, 4'd1, 4'd0);
        B1 = mk(2'b00, 25'h12, 4'd0, 4'd0);
        B2 = mk(2'b00, 25'h13, 4'd0, 4'd0);
        T  = mk(2'b10, 25'h14, 4'd0, 4'd0);
        W  = mk(2'b01, 25'h21, 4'd0, 4'd1);
        WT = mk(2'b10, 25'h22, 4'd0, 4'd0);
        P0 = mk(2'b01, 25'h30, 4'd3, 4'd1);
        P1 = mk(2'b00, 25'h31, 4'd0, 4'd0);
        P2 = mk(2'b00, 25'h32, 4'd0, 4'd0);
        P3 = mk(2'b00, 25'h33, 4'd0, 4'd0);
        P4 = mk(2'b10, 25'h34, 4'd0, 4'd0);
        BD = 35'h000000011;
        Q0 = mk(2'b01, 25'h40, 4'd1, 4'd0);
        Q1 = mk(2'b00, 25'h41, 4'd0, 4'd0);
        L  = mk(2'b11, 25'h50, 4'd1, 4'd1);
        A  = mk(2'b01, 25'h60, 4'd2, 4'd1);
        B  = mk(2'b00, 25'h61, 4'd0, 4'd0);
        A2 = mk(2'b01, 25'h62, 4'd0, 4'd0);
        TT = mk(2'b10, 25'h63, 4'd0, 4'd0);

        //                  rst req din oack  iack oreq route   err data
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00000, 0, '0));  // reset state
        vecs.push_back(v(0, 1, S,  1,  1, 0, 5'b00000, 0, '0));  // single, east
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00000, 0, '0));
        vecs.push_back(v(0, 0, '0, 1,  1, 1, 5'b00100, 0, S));
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00100, 0, '0));
        vecs.push_back(v(0, 1, H,  1,  1, 0, 5'b00100, 0, '0));  // 4-flit packet, south
        vecs.push_back(v(0, 1, B1, 1,  1, 0, 5'b00100, 0, '0));
        vecs.push_back(v(0, 1, B2, 1,  1, 1, 5'b01000, 0, H));
        vecs.push_back(v(0, 1, T,  1,  1, 1, 5'b01000, 0, B1));
        vecs.push_back(v(0, 0, '0, 1,  1, 1, 5'b01000, 0, B2));
        vecs.push_back(v(0, 0, '0, 1,  1, 1, 5'b01000, 0, T));
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b01000, 0, '0));
        vecs.push_back(v(0, 1, W,  1,  1, 0, 5'b01000, 0, '0));  // head west
        vecs.push_back(v(0, 1, WT, 1,  1, 0, 5'b01000, 0, '0));
        vecs.push_back(v(0, 0, '0, 1,  1, 1, 5'b10000, 0, W));
        vecs.push_back(v(0, 0, '0, 1,  1, 1, 5'b10000, 0, WT));
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b10000, 0, '0));
        vecs.push_back(v(0, 1, P0, 0,  1, 0, 5'b10000, 0, '0));  // fill with out_ack low
        vecs.push_back(v(0, 1, P1, 0,  1, 0, 5'b10000, 0, '0));
        vecs.push_back(v(0, 1, P2, 0,  1, 1, 5'b00100, 0, P0));
        vecs.push_back(v(0, 1, P3, 0,  1, 1, 5'b00100, 0, P0));
        vecs.push_back(v(0, 1, P4, 0,  0, 1, 5'b00100, 0, P0));
        vecs.push_back(v(0, 1, P4, 0,  0, 1, 5'b00100, 0, P0));
        vecs.push_back(v(0, 1, P4, 1,  0, 1, 5'b00100, 0, P0));  // read while full
        vecs.push_back(v(0, 1, P4, 0,  1, 1, 5'b00100, 0, P1));
        vecs.push_back(v(0, 0, '0, 1,  0, 1, 5'b00100, 0, P1));
        vecs.push_back(v(0, 0, '0, 1,  1, 1, 5'b00100, 0, P2));
        vecs.push_back(v(0, 0, '0, 1,  1, 1, 5'b00100, 0, P3));
        vecs.push_back(v(0, 0, '0, 1,  1, 1, 5'b00100, 0, P4));
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00100, 0, '0));
        vecs.push_back(v(0, 1, BD, 1,  1, 0, 5'b00100, 0, '0));  // orphan body
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00100, 0, '0));
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00100, 1, '0));
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00100, 1, '0));
        vecs.push_back(v(0, 1, Q0, 1,  1, 0, 5'b00100, 1, '0));  // reset mid-packet
        vecs.push_back(v(0, 1, Q1, 1,  1, 0, 5'b00100, 1, '0));
        vecs.push_back(v(1, 0, '0, 0,  1, 0, 5'b01000, 1, '0));
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00000, 0, '0));
        vecs.push_back(v(0, 1, L,  1,  1, 0, 5'b00000, 0, '0));  // single, local
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00000, 0, '0));
        vecs.push_back(v(0, 0, '0, 1,  1, 1, 5'b00001, 0, L));
        vecs.push_back(v(0, 0, '0, 1,  1, 0, 5'b00001, 0, '0));

        rst = 1'b1; in_req = 1'b0; in_data = '0; out_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++)
            cyc($sformatf("row%0d", i), vecs[i]);

        // Second head arrives before the tail: flagged, forwarded on the old route.
        cyc("seq1", v(0, 1, A,  1,  1, 0, 5'b00001, 0, '0));
        cyc("seq2", v(0, 0, '0, 1,  1, 0, 5'b00001, 0, '0));
        cyc("seq3", v(0, 0, '0, 1,  1, 1, 5'b00100, 0, A));
        cyc("seq4", v(0, 1, B,  1,  1, 0, 5'b00100, 0, '0));
        cyc("seq5", v(0, 0, '0, 1,  1, 1, 5'b00100, 0, B));
        cyc("seq6", v(0, 1, A2, 1,  1, 0, 5'b00100, 0, '0));
        cyc("seq7", v(0, 0, '0, 1,  1, 1, 5'b00100, 0, A2));
        cyc("seq8", v(0, 1, TT, 1,  1, 0, 5'b00100, 1, '0));
        cyc("seq9", v(0, 0, '0, 1,  1, 1, 5'b00100, 1, TT));
        cyc("seq10", v(0, 0, '0, 1, 1, 0, 5'b00100, 1, '0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
